// File: rtl/baw_pkg.sv
// Shared constants and helpers for the Black-and-White card datapath.
// Card colour is the low bit of the card value: odd cards are black.
package baw_pkg;

    localparam int NUM_CARDS = 9;
    localparam int SEL_W     = 16;

    localparam logic [1:0] MATCH_TIE = 2'b00;
    localparam logic [1:0] MATCH_P1  = 2'b01;
    localparam logic [1:0] MATCH_P2  = 2'b10;

    function automatic logic card_is_black(input logic [3:0] value);
        return value[0];
    endfunction

endpackage

// File: rtl/baw_card_count.sv
// Purely combinational: a 9-bit remaining-card mask to black/white counts.
module baw_card_count
    import baw_pkg::*;
(
    input  logic [NUM_CARDS-1:0] card,
    output logic [3:0]           black,
    output logic [3:0]           white
);

    always_comb begin
        // NOTE: both counts get a default before the loop so no path leaves them unassigned (no latch).
        black = '0;
        white = '0;
        for (int n = 0; n < NUM_CARDS; n++) begin
            if (card[n]) begin
                if (card_is_black(4'(n))) begin
                    black = black + 4'd1;
                end else begin
                    white = white + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/baw_card_logic.sv
// Registered core: per-player colour counts, hand-card compare and a
// highest-index-wins priority encoder on the card-select vector.
module baw_card_logic
    import baw_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_CARDS-1:0] p1_card,
    input  logic [NUM_CARDS-1:0] p2_card,
    input  logic [3:0]           p1_handcard,
    input  logic [3:0]           p2_handcard,
    input  logic [SEL_W-1:0]     sel,
    output logic [3:0]           p1_black,
    output logic [3:0]           p1_white,
    output logic [3:0]           p2_black,
    output logic [3:0]           p2_white,
    output logic [1:0]           matchresult,
    output logic [3:0]           sel_index,
    output logic                 sel_valid,
    output logic                 sel_multi
);

    logic [3:0] p1_black_d, p1_white_d, p2_black_d, p2_white_d;
    logic [1:0] match_d;
    logic [3:0] index_d;
    logic       valid_d, multi_d;

    baw_card_count u_p1_count (
        .card  (p1_card),
        .black (p1_black_d),
        .white (p1_white_d)
    );

    baw_card_count u_p2_count (
        .card  (p2_card),
        .black (p2_black_d),
        .white (p2_white_d)
    );

    always_comb begin
        match_d = MATCH_TIE;
        if (p1_handcard > p2_handcard) begin
            match_d = MATCH_P1;
        end else if (p1_handcard < p2_handcard) begin
            match_d = MATCH_P2;
        end
    end

    // Scanning upward lets the highest set bit overwrite lower ones.
    always_comb begin
        index_d = '0;
        for (int i = 0; i < SEL_W; i++) begin
            if (sel[i]) begin
                index_d = 4'(i);
            end
        end
        valid_d = |sel;
        multi_d = |(sel & (sel - SEL_W'(1)));
    end

    // NOTE: output registers use non-blocking assignments and clear asynchronously on resetn.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p1_black    <= '0;
            p1_white    <= '0;
            p2_black    <= '0;
            p2_white    <= '0;
            matchresult <= MATCH_TIE;
            sel_index   <= '0;
            sel_valid   <= 1'b0;
            sel_multi   <= 1'b0;
        end else begin
            p1_black    <= p1_black_d;
            p1_white    <= p1_white_d;
            p2_black    <= p2_black_d;
            p2_white    <= p2_white_d;
            matchresult <= match_d;
            sel_index   <= index_d;
            sel_valid   <= valid_d;
            sel_multi   <= multi_d;
        end
    end

endmodule

// File: tb/tb_baw_card_logic.sv
// Self-checking bench for baw_card_logic: directed vector table, random
// stimulus against a behavioural model, and asynchronous reset sequences.
module tb_baw_card_logic;

    typedef struct {
        logic [8:0]  p1_card;
        logic [8:0]  p2_card;
        logic [3:0]  p1_hc;
        logic [3:0]  p2_hc;
        logic [15:0] sel;
    } stim_t;

    typedef struct {
        logic [3:0] p1b;
        logic [3:0] p1w;
        logic [3:0] p2b;
        logic [3:0] p2w;
        logic [1:0] mr;
        logic [3:0] idx;
        logic       valid;
        logic       multi;
    } resp_t;

    typedef struct {
        stim_t s;
        resp_t r;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [8:0]  p1_card = '0, p2_card = '0;
    logic [3:0]  p1_handcard = '0, p2_handcard = '0;
    logic [15:0] sel = '0;
    logic [3:0]  p1_black, p1_white, p2_black, p2_white;
    logic [1:0]  matchresult;
    logic [3:0]  sel_index;
    logic        sel_valid, sel_multi;

    int checks   = 0;
    int failures = 0;

    resp_t zero_resp = '{p1b: 4'd0, p1w: 4'd0, p2b: 4'd0, p2w: 4'd0, mr: 2'd0,
                         idx: 4'd0, valid: 1'b0, multi: 1'b0};
    resp_t prev;

    always #5 clk = ~clk;

    baw_card_logic dut (
        .clk         (clk),
        .resetn      (resetn),
        .p1_card     (p1_card),
        .p2_card     (p2_card),
        .p1_handcard (p1_handcard),
        .p2_handcard (p2_handcard),
        .sel         (sel),
        .p1_black    (p1_black),
        .p1_white    (p1_white),
        .p2_black    (p2_black),
        .p2_white    (p2_white),
        .matchresult (matchresult),
        .sel_index   (sel_index),
        .sel_valid   (sel_valid),
        .sel_multi   (sel_multi)
    );

    // Reference model straight from the game rules.
    function automatic resp_t model(input stim_t s);
        resp_t r;
        int    ones;
        r = '{p1b: 4'd0, p1w: 4'd0, p2b: 4'd0, p2w: 4'd0, mr: 2'd0,
              idx: 4'd0, valid: 1'b0, multi: 1'b0};
        for (int n = 0; n < 9; n++) begin
            if (s.p1_card[n]) begin
                if (n % 2 == 1) r.p1b = r.p1b + 1; else r.p1w = r.p1w + 1;
            end
            if (s.p2_card[n]) begin
                if (n % 2 == 1) r.p2b = r.p2b + 1; else r.p2w = r.p2w + 1;
            end
        end
        if (int'(s.p1_hc) > int'(s.p2_hc))      r.mr = 2'b01;
        else if (int'(s.p1_hc) < int'(s.p2_hc)) r.mr = 2'b10;
        else                                    r.mr = 2'b00;
        ones = 0;
        for (int i = 15; i >= 0; i--) begin
            if (s.sel[i]) begin
                if (ones == 0) r.idx = 4'(i);
                ones++;
            end
        end
        r.valid = (ones > 0);
        r.multi = (ones >= 2);
        return r;
    endfunction

    function automatic vec_t mk(input logic [8:0] c1, input logic [8:0] c2,
                                input logic [3:0] h1, input logic [3:0] h2,
                                input logic [15:0] sv,
                                input logic [3:0] b1, input logic [3:0] w1,
                                input logic [3:0] b2, input logic [3:0] w2,
                                input logic [1:0] m, input logic [3:0] ix,
                                input logic v, input logic mu);
        vec_t t;
        t.s = '{p1_card: c1, p2_card: c2, p1_hc: h1, p2_hc: h2, sel: sv};
        t.r = '{p1b: b1, p1w: w1, p2b: b2, p2w: w2, mr: m, idx: ix, valid: v, multi: mu};
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input resp_t e);
        check({tag, ".p1_black"},    32'(p1_black),    32'(e.p1b));
        check({tag, ".p1_white"},    32'(p1_white),    32'(e.p1w));
        check({tag, ".p2_black"},    32'(p2_black),    32'(e.p2b));
        check({tag, ".p2_white"},    32'(p2_white),    32'(e.p2w));
        check({tag, ".matchresult"}, 32'(matchresult), 32'(e.mr));
        check({tag, ".sel_index"},   32'(sel_index),   32'(e.idx));
        check({tag, ".sel_valid"},   32'(sel_valid),   32'(e.valid));
        check({tag, ".sel_multi"},   32'(sel_multi),   32'(e.multi));
    endtask

    task automatic drive(input stim_t s);
        p1_card     = s.p1_card;
        p2_card     = s.p2_card;
        p1_handcard = s.p1_hc;
        p2_handcard = s.p2_hc;
        sel         = s.sel;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.p1_card = 9'($urandom);
        s.p2_card = 9'($urandom);
        s.p1_hc   = 4'($urandom_range(0, 15));
        s.p2_hc   = ($urandom_range(0, 3) == 0) ? s.p1_hc : 4'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
            0:       s.sel = 16'h0000;
            1:       s.sel = 16'h0001 << $urandom_range(0, 15);
            default: s.sel = 16'($urandom);
        endcase
        return s;
    endfunction

    // Drive, confirm outputs still hold the previous result, then check one edge later.
    task automatic step(input string tag, input stim_t s, input resp_t e);
        drive(s);
        #1;
        check_outputs({tag, ".hold"}, prev);
        @(posedge clk);
        #1;
        check_outputs(tag, e);
        prev = e;
    endtask

    vec_t  tbl[7];
    stim_t s;

    initial begin
        tbl[0] = mk(9'h1FF, 9'h000, 4'd7,  4'd2,  16'h0000, 4'd4, 4'd5, 4'd0, 4'd0, 2'b01, 4'd0,  1'b0, 1'b0);
        tbl[1] = mk(9'h10A, 9'h1FF, 4'd2,  4'd7,  16'h0001, 4'd2, 4'd1, 4'd4, 4'd5, 2'b10, 4'd0,  1'b1, 1'b0);
        tbl[2] = mk(9'h000, 9'h0AA, 4'd5,  4'd5,  16'h0100, 4'd0, 4'd0, 4'd4, 4'd0, 2'b00, 4'd8,  1'b1, 1'b0);
        tbl[3] = mk(9'h155, 9'h10A, 4'd0,  4'd8,  16'h0012, 4'd0, 4'd5, 4'd2, 4'd1, 2'b10, 4'd4,  1'b1, 1'b1);
        tbl[4] = mk(9'h000, 9'h000, 4'd15, 4'd9,  16'h8001, 4'd0, 4'd0, 4'd0, 4'd0, 2'b01, 4'd15, 1'b1, 1'b1);
        tbl[5] = mk(9'h003, 9'h180, 4'd9,  4'd15, 16'h0200, 4'd1, 4'd1, 4'd1, 4'd1, 2'b10, 4'd9,  1'b1, 1'b0);
        tbl[6] = mk(9'h1FF, 9'h1FF, 4'd12, 4'd12, 16'hFFFF, 4'd4, 4'd5, 4'd4, 4'd5, 2'b00, 4'd15, 1'b1, 1'b1);

        // Power-on reset with arbitrary inputs present.
        s = '{p1_card: 9'h1FF, p2_card: 9'h0AA, p1_hc: 4'd7, p2_hc: 4'd2, sel: 16'h0012};
        drive(s);
        @(posedge clk);
        #1;
        check_outputs("por", zero_resp);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check_outputs("por_release", zero_resp);
        @(posedge clk);
        #1;
        check_outputs("first_edge", model(s));
        prev = model(s);

        for (int i = 0; i < 7; i++) begin
            step($sformatf("vec%0d", i), tbl[i].s, tbl[i].r);
        end

        for (int i = 0; i < 200; i++) begin
            s = rand_stim();
            step($sformatf("rand%0d", i), s, model(s));
        end

        // Mid-stream asynchronous reset between edges, held across an edge.
        s = '{p1_card: 9'h0F0, p2_card: 9'h10F, p1_hc: 4'd3, p2_hc: 4'd4, sel: 16'h0440};
        drive(s);
        @(posedge clk);
        #2;
        check_outputs("pre_reset", model(s));
        resetn = 1'b0;
        #1;
        check_outputs("async_reset", zero_resp);
        @(posedge clk);
        #1;
        check_outputs("reset_held", zero_resp);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check_outputs("reset_released", zero_resp);
        @(posedge clk);
        #1;
        check_outputs("post_reset_edge", model(s));
        prev = model(s);

        for (int i = 0; i < 20; i++) begin
            s = rand_stim();
            step($sformatf("tail%0d", i), s, model(s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
